bus_arbiter: RTL and testbench

- Parametrised N-master arbiter for the shared memory bus used by mips32 cores and DMA-style masters.
- Uses the existing active-low per-master breq_/bgrt_ handshake.
- Grants are registered; ownership is held until the owner releases its request.
- Drives a mux select for address/data routing and a sticky hold-timeout flag for debug.

---
 rtl/bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_bus_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module   : bus_arbiter
// Brief    : N-master bus arbiter, active-low breq_/bgrt_ handshake, registered
//            grants held until release, sticky hold-timeout flag.
//            Optional macro ARB_ROUND_ROBIN_EN selects round-robin priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int IDW         = 2,
    parameter int HOLD_LIMIT  = 64,
    parameter int CNTW        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] breq_,
    output logic [NUM_MASTERS-1:0] bgrt_,
    output logic [IDW-1:0]         owner,
    output logic                   busy,
    output logic [CNTW-1:0]        hold_cnt,
    output logic                   hold_timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CNTW-1:0]        c_cnt_max    = {CNTW{1'b1}};
    localparam logic [CNTW-1:0]        c_hold_limit = CNTW'(HOLD_LIMIT);
    localparam logic [NUM_MASTERS-1:0] c_one        = NUM_MASTERS'(1);

    state_t                   r_state_q, w_state_d;
    logic [IDW-1:0]           r_owner_q, w_owner_d;
    logic [NUM_MASTERS-1:0]   r_bgrt_q,  w_bgrt_d;
    logic [CNTW-1:0]          r_cnt_q,   w_cnt_d;
    logic                     r_to_q,    w_to_d;

    logic [NUM_MASTERS-1:0]   w_cand;
    logic [NUM_MASTERS-1:0]   w_excl;
    logic [IDW-1:0]           w_win;
    logic                     w_found;
    logic                     w_grant_new;

    // The current owner is never a candidate: while holding it is not
    // competing, and on its release edge it may not re-acquire the bus.
    assign w_excl = (r_state_q == ST_GRANT) ? (c_one << r_owner_q) : '0;
    assign w_cand = ~breq_ & ~w_excl;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] r_ptr_q, w_ptr_d;
    logic [IDW-1:0] w_idx;

    // Search cyclically starting just after the pointer; descending k so the
    // nearest requester is the last (winning) assignment.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_idx = IDW'((int'(r_ptr_q) + k) % NUM_MASTERS);
            if (w_cand[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_ptr_d = w_grant_new ? w_win : r_ptr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr_q <= IDW'(NUM_MASTERS - 1);
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end
`else
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_found = 1'b1;
                w_win   = IDW'(i);
            end
        end
    end
`endif

    always_comb begin
        w_state_d   = r_state_q;
        w_owner_d   = r_owner_q;
        w_bgrt_d    = r_bgrt_q;
        w_cnt_d     = r_cnt_q;
        w_grant_new = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant_new = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!breq_[r_owner_q]) begin
                    if (r_cnt_q != c_cnt_max) begin
                        w_cnt_d = r_cnt_q + CNTW'(1);
                    end
                end else if (w_found) begin
                    w_grant_new = 1'b1;
                end else begin
                    w_state_d = ST_IDLE;
                    w_bgrt_d  = '1;
                    w_cnt_d   = '0;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_bgrt_d  = '1;
                w_cnt_d   = '0;
            end
        endcase
        if (w_grant_new) begin
            w_state_d = ST_GRANT;
            w_owner_d = w_win;
            w_bgrt_d  = ~(c_one << w_win);
            w_cnt_d   = CNTW'(1);
        end
        w_to_d = r_to_q | (w_cnt_d == c_hold_limit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_owner_q <= '0;
            r_bgrt_q  <= '1;
            r_cnt_q   <= '0;
            r_to_q    <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_owner_q <= w_owner_d;
            r_bgrt_q  <= w_bgrt_d;
            r_cnt_q   <= w_cnt_d;
            r_to_q    <= w_to_d;
        end
    end

    assign bgrt_        = r_bgrt_q;
    assign owner        = r_owner_q;
    assign busy         = (r_state_q == ST_GRANT);
    assign hold_cnt     = r_cnt_q;
    assign hold_timeout = r_to_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Scoreboard bench for bus_arbiter (4 masters, HOLD_LIMIT=8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  breq_;
    logic [3:0]  bgrt_;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] hold_cnt;
    logic        hold_timeout;

    typedef struct packed {
        logic [3:0]  bgrt;
        logic        busy;
        logic [1:0]  owner;
        logic [15:0] cnt;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    bus_arbiter #(
        .NUM_MASTERS (4),
        .IDW         (2),
        .HOLD_LIMIT  (8),
        .CNTW        (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .breq_        (breq_),
        .bgrt_        (bgrt_),
        .owner        (owner),
        .busy         (busy),
        .hold_cnt     (hold_cnt),
        .hold_timeout (hold_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; the expectation describes the
    // outputs after the following rising edge.
    task automatic vec(input logic r, input logic [3:0] b, input logic [3:0] eg,
                       input logic eb, input logic [1:0] eo, input int ec, input logic et);
        exp_t e;
        @(negedge clk);
        reset = r;
        breq_ = b;
        e.bgrt  = eg;
        e.busy  = eb;
        e.owner = eo;
        e.cnt   = 16'(ec);
        e.to    = et;
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per rising edge while the queue is non-empty.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (bgrt_ !== e.bgrt || busy !== e.busy || owner !== e.owner ||
                    hold_cnt !== e.cnt || hold_timeout !== e.to ||
                    $countones(~bgrt_) > 1) begin
                    n_err++;
                    $display("FAIL vec%0d: got bgrt_=%b busy=%b owner=%0d hold_cnt=%0d to=%b, want bgrt_=%b busy=%b owner=%0d hold_cnt=%0d to=%b",
                             n_vec, bgrt_, busy, owner, hold_cnt, hold_timeout,
                             e.bgrt, e.busy, e.owner, e.cnt, e.to);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        breq_ = 4'b1111;

        // Reset with all requesting, then first grant to master 0
        vec(1, 4'b0000, 4'b1111, 0, 0, 0, 0);
        vec(1, 4'b0000, 4'b1111, 0, 0, 0, 0);
        vec(0, 4'b0000, 4'b1110, 1, 0, 1, 0);
        vec(0, 4'b1111, 4'b1111, 0, 0, 0, 0);

        // Master 2 holds three cycles then releases
        vec(0, 4'b1011, 4'b1011, 1, 2, 1, 0);
        vec(0, 4'b1011, 4'b1011, 1, 2, 2, 0);
        vec(0, 4'b1011, 4'b1011, 1, 2, 3, 0);
        vec(0, 4'b1111, 4'b1111, 0, 2, 0, 0);

        // Master 1 owns, 0 and 3 waiting, 1 releases: direct handover
        vec(0, 4'b1101, 4'b1101, 1, 1, 1, 0);
        vec(0, 4'b0100, 4'b1101, 1, 1, 2, 0);
`ifdef ARB_ROUND_ROBIN_EN
        vec(0, 4'b0110, 4'b0111, 1, 3, 1, 0);
        vec(0, 4'b1111, 4'b1111, 0, 3, 0, 0);

        // All request, each owner releases after one cycle: 0,1,2,3,0
        vec(0, 4'b0000, 4'b1110, 1, 0, 1, 0);
        vec(0, 4'b0001, 4'b1101, 1, 1, 1, 0);
        vec(0, 4'b0010, 4'b1011, 1, 2, 1, 0);
        vec(0, 4'b0100, 4'b0111, 1, 3, 1, 0);
        vec(0, 4'b1000, 4'b1110, 1, 0, 1, 0);
        vec(0, 4'b1111, 4'b1111, 0, 0, 0, 0);
`else
        vec(0, 4'b0110, 4'b1110, 1, 0, 1, 0);
        vec(0, 4'b1111, 4'b1111, 0, 0, 0, 0);

        // All request, each owner releases after one cycle: 0,1,0,1
        vec(0, 4'b0000, 4'b1110, 1, 0, 1, 0);
        vec(0, 4'b0001, 4'b1101, 1, 1, 1, 0);
        vec(0, 4'b0010, 4'b1110, 1, 0, 1, 0);
        vec(0, 4'b0001, 4'b1101, 1, 1, 1, 0);
        vec(0, 4'b1111, 4'b1111, 0, 1, 0, 0);
`endif

        // Master 0 holds ten cycles; flag rises with hold_cnt==8 and sticks
        for (int c = 1; c <= 10; c++) begin
            vec(0, 4'b1110, 4'b1110, 1, 0, c, (c >= 8) ? 1'b1 : 1'b0);
        end
        vec(0, 4'b1111, 4'b1111, 0, 0, 0, 1);
        vec(0, 4'b1111, 4'b1111, 0, 0, 0, 1);

        // Master 3 reaches hold_cnt=5, reset mid-tenure, re-grant afterwards
        for (int c = 1; c <= 5; c++) begin
            vec(0, 4'b0111, 4'b0111, 1, 3, c, 1);
        end
        vec(1, 4'b0111, 4'b1111, 0, 0, 0, 0);
        vec(0, 4'b0111, 4'b0111, 1, 3, 1, 0);
        vec(0, 4'b1111, 4'b1111, 0, 3, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
